// File: rtl/exe_stage.sv
// exe_stage: handshaked execute stage with a registered result and NZCV flag word.
// Handles ADD, SUB, AND, OR, XOR, LSL and LSR with one-cycle latency.
// Build option EXE_STAGE_MUL_EN: when defined, opcode 7 runs a WIDTH-cycle shift-add
// multiplier. When undefined, opcode 7 returns zero with Z set and busy stays low.
module exe_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] reg1_val,
    input  logic [WIDTH-1:0] reg2_val,
    input  logic [WIDTH-1:0] immediate,
    input  logic [2:0]       alu_oc,
    input  logic             ir_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic [31:0]      wr_cpsr_val,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LSL = 3'd5;
    localparam logic [2:0] OP_LSR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

`ifdef EXE_STAGE_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        MUL  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1
    } state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    state_t           issue_state;
    logic             accept;
    logic [WIDTH-1:0] op2;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   lsl_full;
    logic [WIDTH:0]   lsr_full;
    logic [WIDTH:0]   alu_res;
    logic             alu_v;

    // Pack N, Z, C, V into the top nibble of the status word.
    function automatic logic [31:0] mk_flags(input logic [WIDTH:0] r, input logic v);
        mk_flags = {r[WIDTH-1], ~|r[WIDTH-1:0], r[WIDTH], v, 28'd0};
    endfunction

    assign op2      = ir_op ? reg2_val : immediate;
    assign shamt    = op2[SHW-1:0];
    // A new bundle is taken from IDLE, or from HOLD while the old result drains.
    assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
    assign accept   = in_valid & in_ready;

`ifdef EXE_STAGE_MUL_EN
    assign issue_state = (alu_oc == OP_MUL) ? MUL : HOLD;
`else
    assign issue_state = HOLD;
`endif

    // Single-cycle ALU; the extra result bit carries the carry-out or the last bit shifted out.
    always_comb begin
        alu_res  = '0;
        alu_v    = 1'b0;
        lsl_full = {1'b0, reg1_val} << shamt;
        lsr_full = {reg1_val, 1'b0} >> shamt;
        case (alu_oc)
            OP_ADD: begin
                alu_res = {1'b0, reg1_val} + {1'b0, op2};
                alu_v   = (reg1_val[WIDTH-1] == op2[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != reg1_val[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = {1'b0, reg1_val} + {1'b0, ~op2} + (WIDTH+1)'(1);
                alu_v   = (reg1_val[WIDTH-1] != op2[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != reg1_val[WIDTH-1]);
            end
            OP_AND: alu_res = {1'b0, reg1_val & op2};
            OP_OR:  alu_res = {1'b0, reg1_val | op2};
            OP_XOR: alu_res = {1'b0, reg1_val ^ op2};
            OP_LSL: alu_res = lsl_full;
            OP_LSR: alu_res = {lsr_full[0], lsr_full[WIDTH:1]};
            // Product comes from the sequencer when enabled; otherwise the result is zero.
            OP_MUL: alu_res = '0;
        endcase
    end

`ifdef EXE_STAGE_MUL_EN
    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    logic [CNTW-1:0]    mul_cnt;
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_mcand;
    logic [2*WIDTH-1:0] mul_sum;
    logic [WIDTH-1:0]   mul_mplier;
    logic [WIDTH:0]     mul_res;
    logic               mul_done;

    assign mul_sum  = mul_acc + (mul_mcand & {(2*WIDTH){mul_mplier[0]}});
    assign mul_res  = {|mul_sum[2*WIDTH-1:WIDTH], mul_sum[WIDTH-1:0]};
    assign mul_done = (mul_cnt == CNTW'(WIDTH - 1));

    // Shift-add multiplier: one partial product per cycle while in MUL.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
        end else if (accept && (alu_oc == OP_MUL)) begin
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= {{WIDTH{1'b0}}, reg1_val};
            mul_mplier <= op2;
        end else if (state_q == MUL) begin
            mul_cnt    <= mul_cnt + CNTW'(1);
            mul_acc    <= mul_sum;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = issue_state;
            end
            HOLD: begin
                if (accept)         state_d = issue_state;
                else if (out_ready) state_d = IDLE;
            end
`ifdef EXE_STAGE_MUL_EN
            MUL: begin
                if (mul_done) state_d = HOLD;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State register and registered result/flags/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid   <= 1'b0;
            result      <= '0;
            wr_cpsr_val <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d == HOLD);
            if (accept && (issue_state == HOLD)) begin
                result      <= alu_res;
                wr_cpsr_val <= mk_flags(alu_res, alu_v);
            end
`ifdef EXE_STAGE_MUL_EN
            else if ((state_q == MUL) && mul_done) begin
                result      <= mul_res;
                wr_cpsr_val <= mk_flags(mul_res, 1'b0);
            end
`endif
        end
    end

`ifdef EXE_STAGE_MUL_EN
    // Busy mirrors residency in the multiply state.
    always_ff @(posedge clk) begin
        if (rst) busy <= 1'b0;
        else     busy <= (state_d == MUL);
    end
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vectors against a behavioural model of exe_stage (WIDTH=32).
module tb_exe_stage;

    localparam int unsigned W = 32;
`ifdef EXE_STAGE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] reg1_val;
    logic [31:0] reg2_val;
    logic [31:0] immediate;
    logic [2:0]  alu_oc;
    logic        ir_op;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] result;
    logic [31:0] wr_cpsr_val;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exe_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reg1_val   (reg1_val),
        .reg2_val   (reg2_val),
        .immediate  (immediate),
        .alu_oc     (alu_oc),
        .ir_op      (ir_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .wr_cpsr_val(wr_cpsr_val),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic done with wide integers, independent of any bit-level structure.
    task automatic golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [32:0] r, output logic [31:0] f);
        longint     sa;
        longint     sb;
        longint     s;
        logic [63:0] p;
        int         sh;
        logic       v;
        v  = 1'b0;
        sh = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (op)
            3'd0: begin
                p = 64'(a) + 64'(b);
                r = p[32:0];
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = {(a >= b), a - b};
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = {1'b0, a & b};
            3'd3: r = {1'b0, a | b};
            3'd4: r = {1'b0, a ^ b};
            3'd5: begin
                p = 64'(a) << sh;
                r = p[32:0];
            end
            3'd6: r = {(sh == 0) ? 1'b0 : a[sh-1], a >> sh};
            default: begin
                if (MUL_EN) begin
                    p = 64'(a) * 64'(b);
                    r = {|p[63:32], p[31:0]};
                end else begin
                    r = '0;
                end
            end
        endcase
        f = {r[31], (r[31:0] == 32'd0), r[32], v, 28'd0};
    endtask

    // Behavioural model state: pending multiply countdown, output slot.
    logic        m_valid  = 1'b0;
    int          m_busy   = 0;
    logic [32:0] m_res    = '0;
    logic [31:0] m_flags  = '0;
    logic [32:0] m_pend   = '0;
    logic [31:0] m_pflags = '0;
    bit          chk_en   = 1'b0;

    function automatic logic model_in_ready();
        return !rst && (m_busy == 0) && (!m_valid || out_ready);
    endfunction

    always @(posedge clk) begin
        logic        acc;
        logic [32:0] gr;
        logic [31:0] gf;
        logic [31:0] b;
        acc = in_valid && model_in_ready();
        if (rst) begin
            m_valid = 1'b0;
            m_busy  = 0;
            m_res   = '0;
            m_flags = '0;
        end else begin
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid = 1'b1;
                    m_res   = m_pend;
                    m_flags = m_pflags;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (acc) begin
                b = ir_op ? reg2_val : immediate;
                golden(alu_oc, reg1_val, b, gr, gf);
                if ((alu_oc == 3'd7) && MUL_EN) begin
                    m_busy   = W;
                    m_pend   = gr;
                    m_pflags = gf;
                    m_valid  = 1'b0;
                end else begin
                    m_valid = 1'b1;
                    m_res   = gr;
                    m_flags = gf;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(model_in_ready()));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("busy", 64'(busy), 64'(m_busy > 0));
            if (m_valid) begin
                chk("result", 64'(result), 64'(m_res));
                chk("flags", 64'(wr_cpsr_val), 64'(m_flags));
            end
        end
    end

    // Present a bundle at posedge+1 and hold it until taken; returns at posedge+1 after transfer.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_reg, output int waited);
        bit ok;
        ok       = 1'b0;
        waited   = 0;
        alu_oc   = op;
        reg1_val = a;
        ir_op    = use_reg;
        if (use_reg) begin
            reg2_val  = b;
            immediate = 32'hDEAD_BEEF;
        end else begin
            immediate = b;
            reg2_val  = 32'hBAAD_F00D;
        end
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        alu_oc    = ~op;
        reg1_val  = ~a;
        reg2_val  = ~reg2_val;
        immediate = ~immediate;
        ir_op     = ~use_reg;
    endtask

    // Wait for out_valid and compare against hand-computed literals.
    task automatic wait_result(input string name, input logic [32:0] er, input logic [31:0] ef,
                               output int busy_cycles);
        bit ok;
        ok          = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_timeout"}, 64'(ok), 64'd1);
        if (ok) begin
            chk({name, "_res"}, 64'(result), 64'(er));
            chk({name, "_flags"}, 64'(wr_cpsr_val), 64'(ef));
        end
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  v_op   [12];
    logic [31:0] v_a    [12];
    logic [31:0] v_b    [12];
    logic        v_reg  [12];
    logic [32:0] v_res  [12];
    logic [31:0] v_flg  [12];

    initial begin
        int waited;
        int bc;
        v_op  = '{3'd0, 3'd1, 3'd5, 3'd3, 3'd4, 3'd6, 3'd1, 3'd0, 3'd5, 3'd1, 3'd7, 3'd7};
        v_a   = '{32'h7FFF_FFFF, 32'h5, 32'h8000_0001, 32'hF0F0_0000, 32'hFFFF_FFFF, 32'h3,
                  32'h3, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0001_0000, 32'h3};
        v_b   = '{32'h1, 32'h5, 32'h1, 32'h0F0F_0000, 32'hFFFF_FFFF, 32'h1,
                  32'h5, 32'h1, 32'h20, 32'h1, 32'h0001_0000, 32'h5};
        v_reg = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        v_res = '{33'h0_8000_0000, 33'h1_0000_0000, 33'h1_0000_0002, 33'h0_FFFF_0000,
                  33'h0_0000_0000, 33'h1_0000_0001, 33'h0_FFFF_FFFE, 33'h1_0000_0000,
                  33'h0_1234_5678, 33'h1_7FFF_FFFF,
                  MUL_EN ? 33'h1_0000_0000 : 33'h0, MUL_EN ? 33'h0_0000_000F : 33'h0};
        v_flg = '{32'h9000_0000, 32'h6000_0000, 32'h2000_0000, 32'h8000_0000,
                  32'h4000_0000, 32'h2000_0000, 32'h8000_0000, 32'h6000_0000,
                  32'h0000_0000, 32'h3000_0000,
                  MUL_EN ? 32'h6000_0000 : 32'h4000_0000, MUL_EN ? 32'h0 : 32'h4000_0000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_oc    = 3'd0;
        reg1_val  = '0;
        reg2_val  = '0;
        immediate = '0;
        ir_op     = 1'b0;

        // Reset state.
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(wr_cpsr_val), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors with literal expectations.
        for (int i = 0; i < 12; i++) begin
            send(v_op[i], v_a[i], v_b[i], v_reg[i], waited);
            wait_result($sformatf("vec%0d", i), v_res[i], v_flg[i], bc);
            if (v_op[i] == 3'd7) chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), MUL_EN ? 64'd32 : 64'd0);
        end

        // Back-to-back single-cycle ops at full throughput.
        for (int i = 0; i < 4; i++) begin
            send(3'(i), 32'h1000 + 32'(i), 32'h0F0F + 32'(i * 3), 1'(i), waited);
            chk("b2b_wait", 64'(waited), 64'd0);
        end
        @(posedge clk);
        #1;

        // Back-pressure on an AND result.
        out_ready = 1'b0;
        send(3'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, waited);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_res", 64'(result), 64'h0_0F00_0F00);
            chk("bp_flags", 64'(wr_cpsr_val), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(3'd0, 32'd1, 32'd2, 1'b0, waited);
        chk("bp_release_wait", 64'(waited), 64'd0);
        wait_result("bp_next", 33'd3, 32'd0, bc);

        // Reset mid-operation discards it.
`ifdef EXE_STAGE_MUL_EN
        send(3'd7, 32'd7, 32'd9, 1'b1, waited);
        repeat (9) @(posedge clk);
`else
        out_ready = 1'b0;
        send(3'd0, 32'd1, 32'd1, 1'b1, waited);
        repeat (2) @(posedge clk);
`endif
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_release_ready", 64'(in_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        send(3'd0, 32'd2, 32'd3, 1'b0, waited);
        wait_result("after_rst", 33'd5, 32'd0, bc);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
